timer_ctrl: RTL and testbench
=============================

// Module: timer_ctrl
// PURPOSE
//  Controller for a chain of NDIG cascaded BCD down-counters (counter_down10 style: level load, enabled, rco_L).
//  Collects keypad digits into an entry buffer, loads them into the counters, and sequences run/pause.
//  Issues per-digit count enables from a prescaled tick and flags completion when every digit reaches 0.
//  Sits between keypad/buttons and the counter datapath of the timer.
// PARAMETERS
//  NDIG        2   number of BCD digits in the counter chain (digit 0 = least significant)
//  TICK_DIV    4   clk cycles per count tick (>=2)
//  DONE_CYCLES 3   cycles done stays high before returning to IDLE (>=1)
// PORTS
//  clk        in   1        clock, all state on posedge
//  rst        in   1        synchronous, active-low reset
//  key_valid  in   1        one-cycle strobe, key_digit valid
//  key_digit  in   4        BCD digit; values >9 ignored
//  start      in   1        start / resume request (level sampled each cycle)
//  stop       in   1        pause (RUN) / clear (ENTRY, PAUSE, DONE)
//  door_open  in   1        interlock input; used only when TIMER_DOOR_INTERLOCK_EN is defined
//  zero_L     in   NDIG     rco_L of each counter; 0 = that digit currently 0
//  ld         out  1        load pulse to all counters
//  ld_digits  out  4*NDIG   entry buffer, digit i at [4i+3:4i], drives counter in ports
//  cnt_en     out  NDIG     per-digit enable
//  running    out  1        1 in RUN
//  done       out  1        1 in DONE
//  state_o    out  3        current state encoding
// BEHAVIOUR
//  States: IDLE=0 ENTRY=1 LOAD=2 RUN=3 PAUSE=4 DONE=5; all outputs registered or decoded from state only.
//  Reset (rst=0 at posedge, any state): state IDLE, buffer 0, prescaler 0, ld=0, ld_digits=0, cnt_en=0, running=0, done=0, state_o=0.
//  Same-cycle priority: stop > start > key_valid.
//  IDLE/ENTRY: valid key (<=9) shifts buffer left one digit, new digit into digit 0, MSD dropped; IDLE->ENTRY.
//  ENTRY: start with buffer!=0 -> LOAD; start with buffer==0 ignored; stop -> IDLE, buffer cleared.
//  LOAD: ld=1 for exactly one cycle, then RUN; prescaler cleared to 0.
//  RUN: prescaler counts 0..TICK_DIV-1; tick = (prescaler==TICK_DIV-1).
//   cnt_en[0]=tick; cnt_en[i]=tick & all zero_L[i-1:0]==0 (borrow cascade, lower digits wrap 0->9).
//   all zero_L==0 -> cnt_en forced 0 (never wraps to 9..9), next state DONE.
//   stop -> PAUSE (cnt_en 0 in that cycle); key_valid ignored.
//  PAUSE: cnt_en=0, prescaler held; start -> RUN resuming prescaler value (no reload); stop -> IDLE, buffer cleared.
//  DONE: done=1 for DONE_CYCLES cycles then IDLE, buffer cleared; stop -> IDLE immediately; start/keys ignored.
//  First tick after LOAD lands TICK_DIV cycles after entering RUN.
// CONFIGURATION
//  TIMER_DOOR_INTERLOCK_EN defined: door_open=1 in RUN -> PAUSE same as stop; start ignored while door_open=1
//   in ENTRY and PAUSE. Not defined: door_open unused, no effect on any state or output.
// TESTING (bench: NDIG=2, TICK_DIV=4, DONE_CYCLES=3, behavioural down10 counter models on outputs)
//  rst=0 for 2 cycles mid-RUN -> next cycle state_o=0, cnt_en=00, ld=0, done=0, counters hold.
//  keys 1,2,3 then 0xA -> ld_digits=0x23; start -> one ld pulse, counters 23, running=1.
//  load 10, run -> after 4 cycles cnt_en=01 (09? no: 10 -> cnt_en=11 -> 09); next ticks 08,07,...
//  load 02 -> ticks to 01,00; then done=1 for exactly 3 cycles, state_o 5->0; counters stay 00, never 99.
//  RUN with prescaler=2, stop -> PAUSE, cnt_en=00 for 20 cycles; start -> tick 2 cycles later.
//  start with buffer 00 -> stays ENTRY; start&stop same cycle in ENTRY -> IDLE.
//  with TIMER_DOOR_INTERLOCK_EN: door_open=1 in RUN -> PAUSE; start while door_open=1 ignored; door closed+start -> RUN.

Source files
------------

// File: rtl/timer_ctrl.sv
// Keypad/run/pause sequencer for a chain of NDIG cascaded BCD down-counters.
// Optional door interlock enabled by defining TIMER_DOOR_INTERLOCK_EN.
module timer_ctrl #(
    parameter int NDIG        = 2,
    parameter int TICK_DIV    = 4,
    parameter int DONE_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [3:0]        key_digit,
    input  logic              start,
    input  logic              stop,
    input  logic              door_open,
    input  logic [NDIG-1:0]   zero_L,
    output logic              ld,
    output logic [4*NDIG-1:0] ld_digits,
    output logic [NDIG-1:0]   cnt_en,
    output logic              running,
    output logic              done,
    output logic [2:0]        state_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DONE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state;
    logic [4*NDIG-1:0]   buf_q;
    logic [4*NDIG-1:0]   shifted;
    logic [PW-1:0]       presc;
    logic [DW-1:0]       done_cnt;
    logic                door_hold;
    logic                key_ok;
    logic                buf_nz;
    logic                all_zero;
    logic                tick;
    logic                pause_req;
    logic                borrow;

`ifdef TIMER_DOOR_INTERLOCK_EN
    assign door_hold = door_open;
`else
    logic unused_door;
    assign unused_door = door_open;
    assign door_hold   = 1'b0;
`endif

    assign key_ok    = key_valid && (key_digit <= 4'd9);
    assign buf_nz    = |buf_q;
    assign all_zero  = ~|zero_L;
    assign tick      = (presc == PW'(TICK_DIV - 1));
    assign pause_req = stop | door_hold;

    always_comb begin
        shifted      = buf_q << 4;
        shifted[3:0] = key_digit;
    end

    // Borrow cascade: a digit counts only when every lower digit is at 0 and wraps to 9.
    // Once all digits read 0 the enables are held off so the chain never wraps to 9..9.
    always_comb begin
        cnt_en = '0;
        borrow = tick;
        if (rst && (state == S_RUN) && !pause_req && !all_zero) begin
            for (int i = 0; i < NDIG; i++) begin
                cnt_en[i] = borrow;
                borrow    = borrow & ~zero_L[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            buf_q    <= '0;
            presc    <= '0;
            done_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (stop) begin
                        buf_q <= '0;
                    end else if (key_ok) begin
                        buf_q <= shifted;
                        state <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (stop) begin
                        buf_q <= '0;
                        state <= S_IDLE;
                    end else if (start && buf_nz && !door_hold) begin
                        state <= S_LOAD;
                    end else if (key_ok) begin
                        buf_q <= shifted;
                    end
                end
                S_LOAD: begin
                    presc <= '0;
                    state <= S_RUN;
                end
                // Prescaler is frozen on pause so a resume continues the interrupted tick period.
                S_RUN: begin
                    if (pause_req) begin
                        state <= S_PAUSE;
                    end else if (all_zero) begin
                        done_cnt <= '0;
                        state    <= S_DONE;
                    end else begin
                        presc <= tick ? '0 : presc + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (stop) begin
                        buf_q <= '0;
                        state <= S_IDLE;
                    end else if (start && !door_hold) begin
                        state <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (stop || (done_cnt == DW'(DONE_CYCLES - 1))) begin
                        buf_q <= '0;
                        state <= S_IDLE;
                    end else begin
                        done_cnt <= done_cnt + DW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ld        = (state == S_LOAD);
    assign running   = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign state_o   = state;
    assign ld_digits = buf_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl driving two behavioural BCD down-counters.
module tb_timer_ctrl;

    localparam int NDIG = 2;

    localparam int O_ST  = 0;
    localparam int O_LD  = 1;
    localparam int O_EN  = 2;
    localparam int O_RUN = 3;
    localparam int O_DN  = 4;
    localparam int O_DIG = 5;
    localparam int O_CNT = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              key_valid = 1'b0;
    logic [3:0]        key_digit = 4'd0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              door_open = 1'b0;
    logic [NDIG-1:0]   zero_L;
    logic              ld;
    logic [4*NDIG-1:0] ld_digits;
    logic [NDIG-1:0]   cnt_en;
    logic              running;
    logic              done;
    logic [2:0]        state_o;

    logic [3:0] c0 = 4'd0;
    logic [3:0] c1 = 4'd0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    timer_ctrl #(.NDIG(NDIG), .TICK_DIV(4), .DONE_CYCLES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .start     (start),
        .stop      (stop),
        .door_open (door_open),
        .zero_L    (zero_L),
        .ld        (ld),
        .ld_digits (ld_digits),
        .cnt_en    (cnt_en),
        .running   (running),
        .done      (done),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    // Behavioural down10 counters: level load, enable, wrap 0 -> 9
    always @(posedge clk) begin
        if (ld) begin
            c0 <= ld_digits[3:0];
            c1 <= ld_digits[7:4];
        end else begin
            if (cnt_en[0]) c0 <= (c0 == 4'd0) ? 4'd9 : c0 - 4'd1;
            if (cnt_en[1]) c1 <= (c1 == 4'd0) ? 4'd9 : c1 - 4'd1;
        end
    end
    assign zero_L = {c1 != 4'd0, c0 != 4'd0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            O_ST:    return 32'(state_o);
            O_LD:    return 32'(ld);
            O_EN:    return 32'(cnt_en);
            O_RUN:   return 32'(running);
            O_DN:    return 32'(done);
            O_DIG:   return 32'(ld_digits);
            default: return 32'({c1, c0});
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        cyc();
        key_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(2);
        push("rst_state", O_ST, 0); push("rst_ld", O_LD, 0); push("rst_en", O_EN, 0);
        push("rst_run", O_RUN, 0); push("rst_done", O_DN, 0); push("rst_dig", O_DIG, 0);
        drain();
        rst = 1'b1;

        // Entry, MSD drop, illegal key, load and first tick
        press(4'd1);
        push("entry_state", O_ST, 1); push("buf_1", O_DIG, 'h01); drain();
        press(4'd2); press(4'd3); press(4'hA);
        push("buf_23", O_DIG, 'h23); push("entry_state2", O_ST, 1); drain();
        go();
        push("load_ld", O_LD, 1); push("load_state", O_ST, 2); drain();
        cyc();
        push("ld_once", O_LD, 0); push("run_flag", O_RUN, 1); push("cnt_23", O_CNT, 'h23); drain();
        cyc(3);
        push("first_tick", O_EN, 'b01); drain();
        cyc();
        push("cnt_22", O_CNT, 'h22); drain();

        // Reset in the middle of RUN
        rst = 1'b0;
        cyc(2);
        push("mrst_state", O_ST, 0); push("mrst_en", O_EN, 0); push("mrst_ld", O_LD, 0);
        push("mrst_done", O_DN, 0); push("mrst_hold", O_CNT, 'h22); push("mrst_dig", O_DIG, 0);
        drain();
        rst = 1'b1;

        // Borrow cascade from 10, pause/resume with prescaler at 2
        press(4'd1); press(4'd0);
        push("buf_10", O_DIG, 'h10); drain();
        go(); cyc();
        push("cnt_10", O_CNT, 'h10); drain();
        cyc(3);
        push("borrow_en", O_EN, 'b11); drain();
        cyc();
        push("cnt_09", O_CNT, 'h09); drain();
        cyc(3);
        push("tick_en", O_EN, 'b01); drain();
        cyc();
        push("cnt_08", O_CNT, 'h08); drain();
        cyc(2);
        stop = 1'b1;
        push("stop_en", O_EN, 0); drain();
        cyc();
        stop = 1'b0;
        push("pause_state", O_ST, 4); drain();
        for (int i = 0; i < 20; i++) begin
            push("pause_en", O_EN, 0); drain();
            cyc();
        end
        push("pause_hold", O_CNT, 'h08); drain();
        go();
        push("resume_state", O_ST, 3); push("resume_en0", O_EN, 0); drain();
        cyc();
        push("resume_tick", O_EN, 'b01); drain();
        cyc();
        push("cnt_07", O_CNT, 'h07); drain();
        stop = 1'b1;
        cyc();
        push("stop_pause", O_ST, 4); drain();
        cyc();
        stop = 1'b0;
        push("stop_idle", O_ST, 0); push("stop_clr", O_DIG, 0); drain();

        // Count down to zero and DONE window
        press(4'd0);
        push("zero_key_entry", O_ST, 1); push("zero_key_buf", O_DIG, 0); drain();
        press(4'd2);
        go(); cyc();
        push("cnt_02", O_CNT, 'h02); drain();
        cyc(3);
        push("tick_02", O_EN, 'b01); drain();
        cyc();
        push("cnt_01", O_CNT, 'h01); drain();
        cyc(3);
        push("tick_01", O_EN, 'b01); drain();
        cyc();
        push("cnt_00", O_CNT, 'h00); push("zero_en", O_EN, 0); push("zero_run", O_ST, 3); drain();
        for (int i = 0; i < 3; i++) begin
            cyc();
            push("done_flag", O_DN, 1); push("done_state", O_ST, 5); push("done_cnt", O_CNT, 'h00);
            drain();
        end
        cyc();
        push("after_done_state", O_ST, 0); push("after_done_flag", O_DN, 0);
        push("after_done_clr", O_DIG, 0); push("after_done_cnt", O_CNT, 'h00); drain();
        cyc(5);
        push("no_wrap", O_CNT, 'h00); drain();

        // Entry corner cases
        press(4'hF);
        push("bad_key_idle", O_ST, 0); push("bad_key_buf", O_DIG, 0); drain();
        press(4'd0);
        go();
        push("start_zero_buf", O_ST, 1); drain();
        press(4'd5);
        push("buf_05", O_DIG, 'h05); drain();
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        push("start_stop_idle", O_ST, 0); push("start_stop_clr", O_DIG, 0); drain();

        // Stop during DONE returns to IDLE at once
        press(4'd1);
        go(); cyc(); cyc(3); cyc(); cyc();
        push("done_entry", O_ST, 5); drain();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        push("done_stop", O_ST, 0); push("done_stop_flag", O_DN, 0); drain();

`ifdef TIMER_DOOR_INTERLOCK_EN
        press(4'd5);
        go(); cyc();
        door_open = 1'b1;
        push("door_en", O_EN, 0); drain();
        cyc();
        push("door_pause", O_ST, 4); drain();
        start = 1'b1;
        cyc();
        push("door_block", O_ST, 4); drain();
        door_open = 1'b0;
        cyc();
        start = 1'b0;
        push("door_resume", O_ST, 3); drain();
        stop = 1'b1;
        cyc(2);
        stop = 1'b0;
        push("door_exit", O_ST, 0); drain();
`else
        press(4'd5);
        go(); cyc();
        door_open = 1'b1;
        cyc();
        push("door_ignored", O_ST, 3); drain();
        door_open = 1'b0;
        stop = 1'b1;
        cyc(2);
        stop = 1'b0;
        push("door_exit", O_ST, 0); drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
